// File: rtl/mem_wb_bus_if_pkg.sv
// Shared definitions for the memory-stage Wishbone master: state encodings,
// stall-vector width and the common reset/zero constants.
package mem_wb_bus_if_pkg;

    localparam int          STALL_BUS_W = 6;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic        RST_ENABLE  = 1'b0;

    typedef enum logic [1:0] {
        BUS_IDLE       = 2'd0,
        BUS_BUSY       = 2'd1,
        BUS_WAIT_STALL = 2'd2
    } bus_state_e;

    // Counter only needs to reach timeout-1; never narrower than 8 bits.
    function automatic int cnt_width(input int unsigned timeout);
        if (timeout <= 255) return 8;
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_wb_bus_if.sv
// Wishbone B3 classic data-side master for the memory-access stage: turns a
// one-cycle load/store request into a bus cycle and holds the pipeline meanwhile.
module mem_wb_bus_if
    import mem_wb_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_BUS_W-1:0] stall_i,
    input  logic                   flush_i,
    input  logic                   cpu_ce_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic [31:0]            cpu_data_i,
    input  logic                   cpu_we_i,
    input  logic [3:0]             cpu_sel_i,
    output logic [31:0]            cpu_data_o,
    output logic                   stallreq_o,
    output logic                   bus_err_o,
    output logic [31:0]            wb_addr_o,
    output logic [31:0]            wb_data_o,
    output logic                   wb_we_o,
    output logic [3:0]             wb_sel_o,
    output logic                   wb_stb_o,
    output logic                   wb_cyc_o,
    input  logic [31:0]            wb_data_i,
    input  logic                   wb_ack_i,
    output logic [1:0]             dbg_state
);

    localparam int              CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    bus_state_e       state;
    logic [31:0]      rd_buf;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);
    assign dbg_state   = state;

    // Handshake: STB and CYC rise and fall together; ADR/DAT/SEL/WE are frozen
    // while STB is high; an ACK is only honoured in BUSY, i.e. while STB is high.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state     <= BUS_IDLE;
            wb_addr_o <= ZERO_WORD;
            wb_data_o <= ZERO_WORD;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'h0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            rd_buf    <= ZERO_WORD;
            cnt       <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                BUS_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wb_addr_o <= cpu_addr_i;
                        wb_data_o <= cpu_data_i;
                        wb_we_o   <= cpu_we_i;
                        wb_sel_o  <= cpu_sel_i;
                        wb_stb_o  <= 1'b1;
                        wb_cyc_o  <= 1'b1;
                        cnt       <= '0;
                        state     <= BUS_BUSY;
                    end
                end
                BUS_BUSY: begin
                    if (flush_i) begin
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= 4'h0;
                        rd_buf   <= ZERO_WORD;
                        state    <= BUS_IDLE;
                    end else if (wb_ack_i) begin
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= 4'h0;
                        rd_buf   <= wb_we_o ? ZERO_WORD : wb_data_i;
                        state    <= (stall_i != '0) ? BUS_WAIT_STALL : BUS_IDLE;
                    end else if (timeout_hit) begin
                        wb_stb_o  <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= 4'h0;
                        rd_buf    <= ZERO_WORD;
                        bus_err_o <= 1'b1;
                        state     <= BUS_IDLE;
                    end else if (cnt != '1) begin
                        // Saturates so an untimed transaction cannot wrap.
                        cnt <= cnt + 1'b1;
                    end
                end
                BUS_WAIT_STALL: begin
                    if (flush_i) begin
                        rd_buf <= ZERO_WORD;
                        state  <= BUS_IDLE;
                    end else if (stall_i == '0) begin
                        state <= BUS_IDLE;
                    end
                end
                default: state <= BUS_IDLE;
            endcase
        end
    end

    // The pipeline must see the hold in the request cycle itself and must see
    // the load data in the ack cycle itself, hence combinational.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = ZERO_WORD;
        case (state)
            BUS_IDLE: begin
                stallreq_o = cpu_ce_i && !flush_i;
            end
            BUS_BUSY: begin
                if (flush_i) begin
                    stallreq_o = 1'b0;
                end else if (wb_ack_i) begin
                    stallreq_o = 1'b0;
                    cpu_data_o = wb_we_o ? ZERO_WORD : wb_data_i;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            BUS_WAIT_STALL: begin
                cpu_data_o = rd_buf;
            end
            default: begin
                stallreq_o = 1'b0;
                cpu_data_o = ZERO_WORD;
            end
        endcase
    end

endmodule
